// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter and scoreboard for the 8x16-bit register bank.
// The bank has a single write port. The ALU and memory-load write-back paths
// share it through valid/ready handshakes, and contention alternates between them.
// The winning write is registered onto rb_RegWrite/rb_rd/rb_data, so the bank's
// negedge write always sees stable values.
// A per-register pending bit records destinations that have been issued but not
// yet written back. Decode uses it to stall on read-after-write hazards.
//
//   state      | meaning
//   GRANT_ALU  | ALU won the most recent contention cycle (MEM wins the next one)
//   GRANT_MEM  | MEM won the most recent contention cycle (ALU wins the next one)

module regbank_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,

    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,

    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    output logic                hazard,

    output logic                rb_RegWrite,
    output logic [ADDR_W-1:0]   rb_rd,
    output logic [DATA_W-1:0]   rb_data,
    output logic [NUM_REGS-1:0] pending
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t                r_last_grant;
    grant_t                w_last_grant_nxt;

    logic                  w_contention;
    logic                  w_alu_grant;
    logic                  w_mem_grant;
    logic                  w_xfer;
    logic [ADDR_W-1:0]     w_xfer_rd;
    logic [DATA_W-1:0]     w_xfer_data;

    logic                  r_rb_we;
    logic [ADDR_W-1:0]     r_rb_rd;
    logic [DATA_W-1:0]     r_rb_data;

    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_pending_nxt;

    // Arbitration and next fairness state.
    // Grants are suppressed while reset is held, so nothing looks accepted
    // during reset. The grant depends only on the valid bits and the fairness
    // state, never on a requester's data.
    always_comb begin
        w_contention     = 1'b0;
        w_alu_grant      = 1'b0;
        w_mem_grant      = 1'b0;
        w_last_grant_nxt = r_last_grant;
        if (reset_n) begin
            w_contention = alu_valid & mem_valid;
            if (w_contention) begin
                if (r_last_grant == GRANT_ALU) begin
                    w_mem_grant      = 1'b1;
                    w_last_grant_nxt = GRANT_MEM;
                end else begin
                    w_alu_grant      = 1'b1;
                    w_last_grant_nxt = GRANT_ALU;
                end
            end else begin
                w_alu_grant = alu_valid;
                w_mem_grant = mem_valid;
            end
        end
    end

    // Select the winning write. At most one grant is ever active.
    always_comb begin
        w_xfer      = w_alu_grant | w_mem_grant;
        w_xfer_rd   = w_mem_grant ? mem_rd   : alu_rd;
        w_xfer_data = w_mem_grant ? mem_data : alu_data;
    end

    // Fairness state register. Reset leaves ALU as the last winner, so MEM takes
    // the first contention.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GRANT_ALU;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Output stage. The write enable is a one-cycle pulse per transfer.
    // Address and data hold between writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rb_we   <= 1'b0;
            r_rb_rd   <= '0;
            r_rb_data <= '0;
        end else begin
            r_rb_we <= w_xfer;
            if (w_xfer) begin
                r_rb_rd   <= w_xfer_rd;
                r_rb_data <= w_xfer_data;
            end
        end
    end

    // Scoreboard next state. Clearing happens first, so an issue to the same
    // register in the same cycle re-reserves it.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_xfer) begin
            w_pending_nxt[w_xfer_rd] = 1'b0;
        end
        if (issue_valid) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Hazard uses only the registered scoreboard. There is no same-cycle bypass.
    always_comb begin
        hazard = reset_n & (r_pending[rs] | r_pending[rt]);
    end

    // Drive the outputs.
    always_comb begin
        alu_ready   = w_alu_grant;
        mem_ready   = w_mem_grant;
        rb_RegWrite = r_rb_we;
        rb_rd       = r_rb_rd;
        rb_data     = r_rb_data;
        pending     = r_pending;
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter.
// Inputs change 1 ns after a rising edge. Checks run after a short settle, well
// clear of the next rising edge.
// A small model of the register bank captures writes on the falling edge, as the
// real bank does.

module tb_regbank_wb_arbiter;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                alu_valid, mem_valid, issue_valid;
    logic                alu_ready, mem_ready, hazard, rb_RegWrite;
    logic [ADDR_W-1:0]   alu_rd, mem_rd, issue_rd, rs, rt, rb_rd;
    logic [DATA_W-1:0]   alu_data, mem_data, rb_data;
    logic [NUM_REGS-1:0] pending;
    logic [DATA_W-1:0]   bank [NUM_REGS];

    int checks = 0;
    int errors = 0;

    regbank_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs(rs), .rt(rt), .hazard(hazard),
        .rb_RegWrite(rb_RegWrite), .rb_rd(rb_rd), .rb_data(rb_data), .pending(pending)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n && rb_RegWrite) bank[rb_rd] = rb_data;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0; rs = 0; rt = 0;
    endtask

    task automatic test_reset();
        alu_valid = 1; mem_valid = 1; rs = 2;
        settle();
        checks++; if (rb_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rb_RegWrite); end
        checks++; if (rb_rd !== 3'd0 || rb_data !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %0d/%h want 0/0000", rb_rd, rb_data); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL reset_ready_hazard: got %b%b%b want 000", alu_ready, mem_ready, hazard); end
        // Leave reset with ALU writing r7 and r2 reserved, then reset again mid-run.
        mem_valid = 0; alu_rd = 7; alu_data = 16'h7777; issue_valid = 1; issue_rd = 2;
        reset_n = 1;
        tick();
        checks++; if (rb_RegWrite !== 1'b1 || pending !== 8'h04) begin errors++; $display("FAIL pre_reset_activity: got we=%b pending=%h want 1/04", rb_RegWrite, pending); end
        issue_valid = 0;
        reset_n = 0;
        settle();
        checks++; if (rb_RegWrite !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL async_reset: got we=%b pending=%h want 0/00", rb_RegWrite, pending); end
        checks++; if (alu_ready !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got ready=%b hazard=%b want 0/0", alu_ready, hazard); end
        tick();
        alu_rd = 3; alu_data = 16'h00AA;
        reset_n = 1;
        settle();
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rb_RegWrite !== 1'b1 || rb_rd !== 3'd3 || rb_data !== 16'h00AA) begin errors++; $display("FAIL first_write: got %b/%0d/%h want 1/3/00aa", rb_RegWrite, rb_rd, rb_data); end
        tick();
        checks++; if (rb_RegWrite !== 1'b0 || rb_rd !== 3'd3 || rb_data !== 16'h00AA) begin errors++; $display("FAIL write_pulse_end: got %b/%0d/%h want 0/3/00aa", rb_RegWrite, rb_rd, rb_data); end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [3:0] exp_mem = 4'b0101;   // bit i: MEM wins cycle i
        alu_valid = 1; alu_rd = 1; alu_data = 16'h1111;
        mem_valid = 1; mem_rd = 2; mem_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (mem_ready !== exp_mem[i] || alu_ready !== !exp_mem[i]) begin errors++; $display("FAIL contention_grant[%0d]: got alu=%b mem=%b want alu=%b mem=%b", i, alu_ready, mem_ready, !exp_mem[i], exp_mem[i]); end
            tick();
            checks++; if (rb_RegWrite !== 1'b1 || rb_rd !== (exp_mem[i] ? 3'd2 : 3'd1) || rb_data !== (exp_mem[i] ? 16'h2222 : 16'h1111)) begin errors++; $display("FAIL contention_write[%0d]: got %b/%0d/%h want 1/%0d", i, rb_RegWrite, rb_rd, rb_data, exp_mem[i] ? 2 : 1); end
        end
        idle_inputs();
        tick();
        checks++; if (rb_RegWrite !== 1'b0) begin errors++; $display("FAIL idle_no_write: got %b want 0", rb_RegWrite); end
    endtask

    task automatic test_back_pressure();
        alu_valid = 1; alu_rd = 7; alu_data = 16'hBEEF;
        mem_valid = 1; mem_rd = 0; mem_data = 16'h1234;
        settle();
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL bp_grant: got alu=%b mem=%b want 0/1", alu_ready, mem_ready); end
        tick();
        mem_valid = 0;
        settle();
        checks++; if (rb_rd !== 3'd0 || rb_data !== 16'h1234 || rb_RegWrite !== 1'b1) begin errors++; $display("FAIL bp_mem_write: got %b/%0d/%h want 1/0/1234", rb_RegWrite, rb_rd, rb_data); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL bp_alu_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rb_RegWrite !== 1'b1 || rb_rd !== 3'd7 || rb_data !== 16'hBEEF) begin errors++; $display("FAIL bp_alu_write: got %b/%0d/%h want 1/7/beef", rb_RegWrite, rb_rd, rb_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_rd = 5;
        tick();
        issue_valid = 0; rs = 5; rt = 0;
        settle();
        checks++; if (pending !== 8'h20 || hazard !== 1'b1) begin errors++; $display("FAIL sb_rs_hazard: got pending=%h hazard=%b want 20/1", pending, hazard); end
        rs = 0; rt = 5;
        settle();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_rt_hazard: got %b want 1", hazard); end
        rt = 0;
        settle();
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_no_hazard: got %b want 0", hazard); end
        rs = 5; mem_valid = 1; mem_rd = 5; mem_data = 16'h5555;
        settle();
        checks++; if (hazard !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL sb_no_bypass: got hazard=%b ready=%b want 1/1", hazard, mem_ready); end
        tick();
        mem_valid = 0;
        settle();
        checks++; if (pending !== 8'h00 || hazard !== 1'b0) begin errors++; $display("FAIL sb_cleared: got pending=%h hazard=%b want 00/0", pending, hazard); end
        idle_inputs();
    endtask

    task automatic test_collision();
        issue_valid = 1; issue_rd = 4;
        tick();
        alu_valid = 1; alu_rd = 4; alu_data = 16'h4444;
        tick();
        issue_valid = 0; alu_valid = 0;
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL collision_pending: got %h want 10", pending); end
        checks++; if (rb_RegWrite !== 1'b1 || rb_rd !== 3'd4 || rb_data !== 16'h4444) begin errors++; $display("FAIL collision_write: got %b/%0d/%h want 1/4/4444", rb_RegWrite, rb_rd, rb_data); end
        // A write to a register that is not pending still happens and leaves the scoreboard alone.
        mem_valid = 1; mem_rd = 1; mem_data = 16'h0101;
        tick();
        mem_valid = 0;
        checks++; if (pending !== 8'h10 || rb_RegWrite !== 1'b1 || rb_rd !== 3'd1) begin errors++; $display("FAIL nonpending_write: got pending=%h we=%b rd=%0d want 10/1/1", pending, rb_RegWrite, rb_rd); end
        // Issuing to a register that is already pending keeps its bit at 1.
        issue_valid = 1; issue_rd = 4;
        tick();
        issue_valid = 0;
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL reissue_pending: got %h want 10", pending); end
        alu_valid = 1; alu_rd = 4; alu_data = 16'h0404;
        tick();
        alu_valid = 0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL collision_clear: got %h want 00", pending); end
        idle_inputs();
        tick();
    endtask

    task automatic test_same_rd();
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();
        alu_valid = 1; alu_rd = 6; alu_data = 16'h0001;
        mem_valid = 1; mem_rd = 6; mem_data = 16'h0002;
        settle();
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL race_grant: got alu=%b mem=%b want 0/1", alu_ready, mem_ready); end
        tick();
        mem_valid = 0;
        checks++; if (rb_rd !== 3'd6 || rb_data !== 16'h0002) begin errors++; $display("FAIL race_first: got %0d/%h want 6/0002", rb_rd, rb_data); end
        tick();
        alu_valid = 0;
        checks++; if (rb_RegWrite !== 1'b1 || rb_data !== 16'h0001) begin errors++; $display("FAIL race_second: got %b/%h want 1/0001", rb_RegWrite, rb_data); end
        tick();
        checks++; if (bank[6] !== 16'h0001) begin errors++; $display("FAIL race_bank_r6: got %h want 0001", bank[6]); end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) bank[i] = '0;
        idle_inputs();
        reset_n = 0;
        tick();
        tick();
        test_reset();
        test_contention();
        test_back_pressure();
        test_scoreboard();
        test_collision();
        test_same_rd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
